// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch/issue sequencer feeding instr_decoder
module instr_fetch #(
    parameter int         PC_WIDTH    = 4,
    parameter int         INSTR_WIDTH = 11,
    parameter logic [2:0] OP_JMP      = 3'b110,
    parameter logic [2:0] OP_HALT     = 3'b111
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   imem_valid,
    output logic [2:0]             opcode,
    output logic [3:0]             mem_addr,
    output logic [3:0]             imm_val,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t state;

    // Instruction word fields: {opcode, mem_addr, imm_val}
    logic [2:0]          word_op;
    logic [3:0]          word_addr;
    logic [3:0]          word_imm;
    logic [PC_WIDTH-1:0] jmp_target;
    logic [PC_WIDTH-1:0] pc_inc;

    assign word_op    = imem_data[INSTR_WIDTH-1 -: 3];
    assign word_addr  = imem_data[7:4];
    assign word_imm   = imem_data[3:0];
    // Immediate is zero-extended or truncated to the PC width.
    assign jmp_target = PC_WIDTH'(word_imm);
    assign pc_inc     = pc + PC_WIDTH'(1);

    // Sequencer FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            opcode      <= '0;
            mem_addr    <= '0;
            imm_val     <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc        <= '0;
                        imem_addr <= '0;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end

                // Strobe is high for exactly this one cycle.
                S_REQ: begin
                    imem_req <= 1'b0;
                    state    <= S_WAIT;
                end

                // Responses are only looked at here, so late or stray ones elsewhere are dropped.
                S_WAIT: begin
                    if (imem_valid) begin
                        if (word_op == OP_HALT) begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else if (word_op == OP_JMP) begin
                            pc        <= jmp_target;
                            imem_addr <= jmp_target;
                            imem_req  <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            opcode      <= word_op;
                            mem_addr    <= word_addr;
                            imm_val     <= word_imm;
                            pc          <= pc_inc;
                            instr_valid <= 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                end

                // Fields stay put until the decoder takes them; the next fetch uses the advanced pc.
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_addr   <= pc;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end
                end

                S_HALTED: begin
                    if (start) begin
                        pc        <= '0;
                        halted    <= 1'b0;
                        imem_addr <= '0;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic [10:0] imem_data;
    logic        imem_valid;
    logic [2:0]  opcode;
    logic [3:0]  mem_addr;
    logic [3:0]  imm_val;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [3:0]  pc;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .opcode     (opcode),
        .mem_addr   (mem_addr),
        .imm_val    (imm_val),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc),
        .halted     (halted)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Program memory model with programmable response latency
    logic [10:0] mem [16];
    int          lat = 1;
    int          cd = 0;
    logic [3:0]  paddr = '0;
    logic        mem_v = 1'b0;
    logic        force_v = 1'b0;
    logic [10:0] mem_d = '0;
    int          fetch_log[$];

    assign imem_valid = mem_v | force_v;
    assign imem_data  = force_v ? 11'h132 : mem_d;

    always @(posedge clk) begin
        logic       r;
        logic [3:0] a;
        r = imem_req;
        a = imem_addr;
        #1;
        mem_v = 1'b0;
        if (r) begin
            cd    = lat;
            paddr = a;
            fetch_log.push_back(int'(a));
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_v = 1'b1;
                mem_d = mem[paddr];
            end
        end
    end

    // Scoreboard and protocol monitor
    logic [10:0] exp_q[$];
    int          valid_cnt = 0;
    int          req_run = 0;
    int          req_max = 0;
    logic        prev_iv = 1'b0;
    logic        prev_imv = 1'b0;

    always @(negedge clk) begin
        logic [10:0] e;
        #1;
        if (instr_valid) valid_cnt++;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("issue", 32'({opcode, mem_addr, imm_val}), 32'(e));
            end
        end
        if (imem_req) req_run++;
        else req_run = 0;
        if (req_run > req_max) req_max = req_run;
        if (instr_valid && !prev_iv) check_val("valid_after_resp", 32'(prev_imv), 32'd1);
        prev_iv  = instr_valid;
        prev_imv = imem_valid;
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input string tag);
        int n = 0;
        while (!halted && n < 80) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(halted), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 80) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(imem_req), 32'd1);
    endtask

    initial begin
        clear_mem();
        // Reset with start and a stray response asserted
        rst = 1'b1;
        start = 1'b1;
        force_v = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_pc", 32'(pc), 32'd0);
        check_val("rst_fields", 32'({opcode, mem_addr, imm_val}), 32'd0);
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_addr", 32'(imem_addr), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        force_v = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_req", 32'(imem_req), 32'd0);
        check_val("idle_valid", 32'(instr_valid), 32'd0);

        // Straight-line program with minimum latency checks
        mem[0] = 11'h132;
        mem[1] = 11'h332;
        mem[2] = 11'h7FF;
        exp_q.push_back(11'h132);
        exp_q.push_back(11'h332);
        instr_ready = 1'b1;
        fetch_log.delete();
        valid_cnt = 0;
        pulse_start();
        check_val("lat_req", 32'(imem_req), 32'd1);
        check_val("lat_req_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        check_val("lat_mem", 32'(imem_valid), 32'd1);
        @(negedge clk);
        check_val("lat_issue", 32'(instr_valid), 32'd1);
        wait_halted("sl_halted");
        check_val("sl_pc", 32'(pc), 32'd2);
        check_val("sl_valid_cycles", 32'(valid_cnt), 32'd2);
        check_val("sl_sb_left", 32'(exp_q.size()), 32'd0);
        check_val("sl_fetches", 32'(fetch_log.size()), 32'd3);
        check_val("sl_fetch2", 32'(fetch_log[2]), 32'd2);
        check_val("sl_fields_hold", 32'({opcode, mem_addr, imm_val}), 32'h332);

        // Restart from HALTED, then backpressure on the first issue
        exp_q.push_back(11'h132);
        exp_q.push_back(11'h332);
        instr_ready = 1'b0;
        pulse_start();
        check_val("restart_halted", 32'(halted), 32'd0);
        check_val("restart_req", 32'(imem_req), 32'd1);
        check_val("restart_addr", 32'(imem_addr), 32'd0);
        wait_valid("bp_valid");
        for (int i = 0; i < 4; i++) begin
            check_val("bp_hold_valid", 32'(instr_valid), 32'd1);
            check_val("bp_hold_fields", 32'({opcode, mem_addr, imm_val}), 32'h132);
            check_val("bp_no_req", 32'(imem_req), 32'd0);
            if (i < 3) @(negedge clk);
        end
        instr_ready = 1'b1;
        wait_req("bp_req");
        check_val("bp_next_addr", 32'(imem_addr), 32'd1);
        wait_halted("bp_halted");
        check_val("bp_sb_left", 32'(exp_q.size()), 32'd0);

        // Jump: JMP consumed internally, never issued
        clear_mem();
        mem[0] = 11'h605;
        mem[5] = 11'h2A1;
        mem[6] = 11'h7FF;
        exp_q.push_back(11'h2A1);
        fetch_log.delete();
        valid_cnt = 0;
        pulse_start();
        wait_halted("jmp_halted");
        check_val("jmp_fetches", 32'(fetch_log.size()), 32'd3);
        check_val("jmp_fetch0", 32'(fetch_log[0]), 32'd0);
        check_val("jmp_fetch1", 32'(fetch_log[1]), 32'd5);
        check_val("jmp_fetch2", 32'(fetch_log[2]), 32'd6);
        check_val("jmp_pc", 32'(pc), 32'd6);
        check_val("jmp_valid_cycles", 32'(valid_cnt), 32'd1);
        check_val("jmp_sb_left", 32'(exp_q.size()), 32'd0);

        // PC wrap: issue from address 15
        clear_mem();
        mem[0]  = 11'h60F;
        mem[15] = 11'h132;
        instr_ready = 1'b0;
        pulse_start();
        wait_valid("wrap_valid");
        check_val("wrap_pc", 32'(pc), 32'd0);
        check_val("wrap_fields", 32'({opcode, mem_addr, imm_val}), 32'h132);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("wrap_rst_valid", 32'(instr_valid), 32'd0);

        // Slow memory, 3-cycle latency
        clear_mem();
        mem[0] = 11'h132;
        mem[1] = 11'h332;
        mem[2] = 11'h7FF;
        lat = 3;
        exp_q.push_back(11'h132);
        exp_q.push_back(11'h332);
        instr_ready = 1'b1;
        req_max = 0;
        pulse_start();
        wait_halted("slow_halted");
        check_val("slow_req_pulse", 32'(req_max), 32'd1);
        check_val("slow_pc", 32'(pc), 32'd2);
        check_val("slow_sb_left", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT; the late response must be ignored
        pulse_start();
        check_val("mid_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mid_valid", 32'(instr_valid), 32'd0);
        check_val("mid_fields", 32'({opcode, mem_addr, imm_val}), 32'd0);
        check_val("mid_halted", 32'(halted), 32'd0);
        check_val("mid_req_idle", 32'(imem_req), 32'd0);
        check_val("mid_pc", 32'(pc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
